// File: rtl/dff_step_controller.sv
// dff_step_controller: schedules one-cycle round-robin capture strobes for LANES flip-flop lanes, free-running (RUN) or key single-step (STEP).
// Latency: raw input to synchronized value 2 cycles; event to lane_en strobe 1 cycle; key press to strobe 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; lanes always take a strobe, and key presses outside STEP are dropped rather than queued.
module dff_step_controller #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LANES           = 4,
    localparam int unsigned PTR_W          = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_step_n,
    input  logic             sw_enable,
    input  logic             sw_run,
    output logic [LANES-1:0] lane_en,
    output logic [PTR_W-1:0] lane_ptr,
    output logic [1:0]       state,
    output logic [7:0]       strobe_count,
    output logic             beat
);

    // Prescaler period in clk cycles and counter widths
    localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);
    localparam logic [LANES-1:0] LANE0    = LANES'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Input synchronizers
    logic key_s1_q;
    logic key_s2_q;
    logic en_s1_q;
    logic en_s2_q;
    logic run_s1_q;
    logic run_s2_q;

    // Debounce
    logic            key_pressed;
    logic            key_db_q;
    logic            key_db_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            step_req_q;
    logic            step_req_d;

    // Mode and prescaler
    state_e           state_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic             tick;
    logic             strobe_evt;

    // Strobe datapath
    logic [LANES-1:0] lane_en_q;
    logic [LANES-1:0] lane_en_d;
    logic [PTR_W-1:0] lane_ptr_q;
    logic [PTR_W-1:0] lane_ptr_d;
    logic [7:0]       strobe_count_q;
    logic [7:0]       strobe_count_d;
    logic             beat_q;
    logic             beat_d;

    // Two-flop synchronizers: key idles released (high), switches idle off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
        end else begin
            key_s1_q <= key_step_n;
            key_s2_q <= key_s1_q;
            en_s1_q  <= sw_enable;
            en_s2_q  <= en_s1_q;
            run_s1_q <= sw_run;
            run_s2_q <= run_s1_q;
        end
    end

    assign key_pressed = ~key_s2_q;

    // Debounce next state: accept a new key level only after it disagrees for DEBOUNCE_CYCLES cycles
    always_comb begin
        key_db_d   = key_db_q;
        db_cnt_d   = '0;
        step_req_d = 1'b0;
        if (key_pressed != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d   = key_pressed;
                db_cnt_d   = '0;
                // Only the press edge requests a step; release is silent
                step_req_d = key_pressed;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_db_q   <= 1'b0;
            db_cnt_q   <= '0;
            step_req_q <= 1'b0;
        end else begin
            key_db_q   <= key_db_d;
            db_cnt_q   <= db_cnt_d;
            step_req_q <= step_req_d;
        end
    end

    // Mode FSM: every cycle the next mode is taken straight from the synchronized switches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (1'b1)
                !en_s2_q: state_q <= ST_IDLE;
                run_s2_q: state_q <= ST_RUN;
                default:  state_q <= ST_STEP;
            endcase
        end
    end

    // Prescaler next state: counts only while RUN, parked at zero otherwise so RUN entry restarts a full period
    always_comb begin
        pre_cnt_d = '0;
        if (state_q == ST_RUN) begin
            pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign tick = (state_q == ST_RUN) && (pre_cnt_q == PRE_LAST);

    // The registered mode qualifies events, so a switch change takes effect only once it reaches state_q
    assign strobe_evt = tick || ((state_q == ST_STEP) && step_req_q);

    // Strobe datapath next state: fire the pointed lane, advance pointer, count and toggle beat
    always_comb begin
        lane_en_d      = '0;
        lane_ptr_d     = lane_ptr_q;
        strobe_count_d = strobe_count_q;
        beat_d         = beat_q;
        if (strobe_evt) begin
            lane_en_d      = LANE0 << lane_ptr_q;
            lane_ptr_d     = (lane_ptr_q == PTR_LAST) ? '0 : lane_ptr_q + 1'b1;
            strobe_count_d = strobe_count_q + 8'd1;
            beat_d         = ~beat_q;
        end
    end

    // Strobe datapath registers; pointer and count survive mode changes, only reset clears them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_en_q      <= '0;
            lane_ptr_q     <= '0;
            strobe_count_q <= '0;
            beat_q         <= 1'b0;
        end else begin
            lane_en_q      <= lane_en_d;
            lane_ptr_q     <= lane_ptr_d;
            strobe_count_q <= strobe_count_d;
            beat_q         <= beat_d;
        end
    end

    assign lane_en      = lane_en_q;
    assign lane_ptr     = lane_ptr_q;
    assign state        = state_q;
    assign strobe_count = strobe_count_q;
    assign beat         = beat_q;

endmodule

// File: tb/tb_dff_step_controller.sv
// tb_dff_step_controller: directed test-plan scenarios plus random key/switch activity.
// Outputs are compared every cycle against a cycle-level reference built from the behavioural rules.
// Inputs change 2 time units after a rising edge; outputs are sampled at the same point.
module tb_dff_step_controller;

    localparam int unsigned CLK_HZ  = 8;
    localparam int unsigned TICK_HZ = 1;
    localparam int unsigned DB      = 4;
    localparam int unsigned LANES   = 4;
    localparam int          PERIOD  = CLK_HZ / TICK_HZ;
    localparam int          PW      = $clog2(LANES);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             key_step_n = 1'b1;
    logic             sw_enable = 1'b0;
    logic             sw_run = 1'b0;
    logic [LANES-1:0] lane_en;
    logic [PW-1:0]    lane_ptr;
    logic [1:0]       state;
    logic [7:0]       strobe_count;
    logic             beat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_step_controller #(
        .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .DEBOUNCE_CYCLES(DB),
        .LANES(LANES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_step_n(key_step_n),
        .sw_enable(sw_enable),
        .sw_run(sw_run),
        .lane_en(lane_en),
        .lane_ptr(lane_ptr),
        .state(state),
        .strobe_count(strobe_count),
        .beat(beat)
    );

    // ---------------- reference model ----------------
    // Raw inputs seen by the design only after a two-sample delay line.
    bit [2:0] dl0, dl1;        // {key_step_n, sw_enable, sw_run}
    bit [2:0] seen;
    int       m_mode;          // 0 idle, 1 step, 2 run
    int       m_age;           // cycles spent in RUN since entering it
    int       m_disagree;      // consecutive cycles the key disagreed with accepted level
    bit       m_db;            // accepted key level, 1 = pressed
    bit       m_step;          // press accepted in the previous cycle
    int       m_ptr, m_cnt, m_lane;
    bit       m_beat;
    bit       ev, pressed;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl0 = 3'b100; dl1 = 3'b100;
            m_mode = 0; m_age = 0; m_disagree = 0; m_db = 1'b0; m_step = 1'b0;
            m_ptr = 0; m_cnt = 0; m_lane = 0; m_beat = 1'b0;
        end else begin
            // Event from what the design knew before this edge
            ev = (m_mode == 2 && (m_age % PERIOD) == PERIOD - 1) || (m_mode == 1 && m_step);
            m_lane = ev ? (1 << m_ptr) : 0;
            if (ev) begin
                m_ptr  = (m_ptr + 1) % LANES;
                m_cnt  = (m_cnt + 1) % 256;
                m_beat = ~m_beat;
            end
            m_age = (m_mode == 2) ? m_age + 1 : 0;
            seen = dl1;
            pressed = ~seen[2];
            m_step = 1'b0;
            if (pressed == m_db) begin
                m_disagree = 0;
            end else if (m_disagree == DB - 1) begin
                m_db = pressed;
                m_disagree = 0;
                m_step = pressed;
            end else begin
                m_disagree++;
            end
            m_mode = !seen[1] ? 0 : (seen[0] ? 2 : 1);
            dl1 = dl0;
            dl0 = {key_step_n, sw_enable, sw_run};
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare every output against the reference
    task automatic cyc();
        @(posedge clk);
        #2;
        chk("lane_en", 32'(lane_en), 32'(m_lane));
        chk("lane_ptr", 32'(lane_ptr), 32'(m_ptr));
        chk("state", 32'(state), 32'(m_mode));
        chk("strobe_count", 32'(strobe_count), 32'(m_cnt));
        chk("beat", 32'(beat), 32'(m_beat));
    endtask

    // Count strobes over n cycles, remembering the first one and when it came
    task automatic watch(input int ncyc, output int n, output int at, output int lane);
        n = 0; at = -1; lane = 0;
        for (int i = 1; i <= ncyc; i++) begin
            cyc();
            if (lane_en != '0) begin
                n++;
                if (at < 0) begin
                    at = i;
                    lane = 32'(lane_en);
                end
            end
        end
    endtask

    initial begin
        int n, at, lane;

        // Reset state
        repeat (2) cyc();
        chk("rst_lane_en", 32'(lane_en), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(strobe_count), 0);
        reset_n = 1'b1;
        cyc();

        // 1: RUN entry and round-robin cadence
        sw_enable = 1'b1; sw_run = 1'b1;
        cyc(); cyc();
        chk("t1_state_before", 32'(state), 0);
        cyc();
        chk("t1_state_run", 32'(state), 2);
        repeat (7) cyc();
        chk("t1_no_early", 32'(lane_en), 0);
        cyc();
        chk("t1_first", 32'(lane_en), 1);
        for (int i = 1; i < 5; i++) begin
            repeat (7) cyc();
            chk("t1_gap", 32'(lane_en), 0);
            cyc();
            chk("t1_lane", 32'(lane_en), 1 << (i % 4));
        end
        chk("t1_count", 32'(strobe_count), 5);
        chk("t1_beat", 32'(beat), 1);

        // 2: STEP mode, clean press then bounced press
        sw_run = 1'b0;
        repeat (4) cyc();
        chk("t2_state", 32'(state), 1);
        key_step_n = 1'b0;
        watch(10, n, at, lane);
        chk("t2_one_strobe", n, 1);
        chk("t2_latency", at, 7);
        chk("t2_lane", lane, 2);
        key_step_n = 1'b1;
        watch(10, n, at, lane);
        chk("t2_release_silent", n, 0);
        key_step_n = 1'b0; cyc();
        key_step_n = 1'b1; cyc();
        key_step_n = 1'b0;
        watch(10, n, at, lane);
        chk("t2_bounce_one", n, 1);
        chk("t2_bounce_lane", lane, 4);
        key_step_n = 1'b1;
        watch(10, n, at, lane);
        chk("t2_bounce_release", n, 0);

        // 3: presses in IDLE and RUN are dropped; STEP uses preserved pointer
        sw_enable = 1'b0;
        repeat (4) cyc();
        chk("t3_idle", 32'(state), 0);
        key_step_n = 1'b0;
        watch(10, n, at, lane);
        key_step_n = 1'b1;
        chk("t3_idle_no_strobe", n, 0);
        watch(10, n, at, lane);
        chk("t3_idle_ptr", 32'(lane_ptr), 3);
        sw_enable = 1'b1;
        repeat (4) cyc();
        key_step_n = 1'b0;
        watch(10, n, at, lane);
        key_step_n = 1'b1;
        chk("t3_step_one", n, 1);
        chk("t3_step_lane", lane, 8);
        watch(10, n, at, lane);
        sw_run = 1'b1;
        repeat (3) cyc();
        chk("t3_run", 32'(state), 2);
        key_step_n = 1'b0;
        watch(7, n, at, lane);
        chk("t3_run_no_strobe", n, 0);
        chk("t3_run_ptr", 32'(lane_ptr), 0);
        key_step_n = 1'b1;
        repeat (12) cyc();

        // 4: RUN -> IDLE -> RUN keeps pointer, restarts a full period
        reset_n = 1'b0; cyc(); cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("t4_run", 32'(state), 2);
        repeat (16) cyc();
        chk("t4_second", 32'(lane_en), 2);
        chk("t4_ptr2", 32'(lane_ptr), 2);
        sw_enable = 1'b0;
        watch(20, n, at, lane);
        chk("t4_idle_no_strobe", n, 0);
        chk("t4_idle_state", 32'(state), 0);
        chk("t4_idle_ptr", 32'(lane_ptr), 2);
        sw_enable = 1'b1;
        repeat (3) cyc();
        chk("t4_reentry", 32'(state), 2);
        repeat (7) cyc();
        chk("t4_no_early", 32'(lane_en), 0);
        cyc();
        chk("t4_first", 32'(lane_en), 4);

        // 5: asynchronous reset in the middle of a strobe
        repeat (7) cyc();
        cyc();
        chk("t5_lane3", 32'(lane_en), 8);
        reset_n = 1'b0;
        #1;
        chk("t5_lane_drop", 32'(lane_en), 0);
        chk("t5_ptr", 32'(lane_ptr), 0);
        chk("t5_count", 32'(strobe_count), 0);
        chk("t5_state", 32'(state), 0);
        cyc(); cyc();
        reset_n = 1'b1;

        // 6: 256 strobes wrap the counter, pointer and beat
        n = 0;
        for (int i = 0; i < 256 * PERIOD + 40 && n < 256; i++) begin
            cyc();
            if (lane_en != '0) n++;
        end
        chk("t6_strobes", n, 256);
        chk("t6_count_wrap", 32'(strobe_count), 0);
        chk("t6_ptr_wrap", 32'(lane_ptr), 0);
        chk("t6_beat_wrap", 32'(beat), 0);

        // Random key bounce, switch flips and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) sw_enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) sw_run = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) key_step_n = ~key_step_n;
            if ($urandom_range(0, 1499) == 0) begin
                reset_n = 1'b0;
                cyc();
                reset_n = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
